// File: rtl/video_scanner.sv
// video_scanner: VGA-style raster timing generator that presents cell coordinates to the renderer
// and emits colour, syncs and data-enable through a two-stage pipeline. Border option: VIDEO_SCANNER_BORDER_EN.
module video_scanner #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CELL_SHIFT = 4,
    parameter int FIELD_W    = 20,
    parameter int FIELD_H    = 30,
    parameter bit SYNC_NEG   = 1'b1
) (
    input  logic        video_clk,
    input  logic        reset,
    output logic [7:0]  video_x,
    output logic [7:0]  video_y,
    input  logic [23:0] pixel_in,
    output logic [23:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    localparam logic [31:0] H_ACT_END  = 32'(H_ACTIVE);
    localparam logic [31:0] H_SYNC_BEG = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] H_SYNC_END = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_ACT_END  = 32'(V_ACTIVE);
    localparam logic [31:0] V_SYNC_BEG = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] V_SYNC_END = 32'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic sync_level(input logic active);
        return SYNC_NEG ? ~active : active;
    endfunction

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [31:0]   h_pos, v_pos;
    logic          h_act, v_act;
    logic          de_p0, hs_p0, vs_p0, first_p0;
    logic          de_p1_q, hs_p1_q, vs_p1_q, first_p1_q;
    logic [23:0]   pix_sel;
    logic [23:0]   rgb_q;
    logic          hsync_q, vsync_q, de_q, fs_q;

    // Both counters wrap on the same edge at the end of a frame.
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_pos    = 32'(h_cnt_q);
    assign v_pos    = 32'(v_cnt_q);
    assign h_act    = h_pos < H_ACT_END;
    assign v_act    = v_pos < V_ACT_END;
    assign video_x  = h_act ? 8'(h_pos >> CELL_SHIFT) : 8'hFF;
    assign video_y  = v_act ? 8'(v_pos >> CELL_SHIFT) : 8'hFF;
    assign de_p0    = h_act && v_act;
    assign hs_p0    = (h_pos >= H_SYNC_BEG) && (h_pos < H_SYNC_END);
    assign vs_p0    = (v_pos >= V_SYNC_BEG) && (v_pos < V_SYNC_END);
    assign first_p0 = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Stage 1: timing flags aligned with the renderer's registered fetch.
    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            de_p1_q    <= 1'b0;
            hs_p1_q    <= 1'b0;
            vs_p1_q    <= 1'b0;
            first_p1_q <= 1'b0;
        end else begin
            de_p1_q    <= de_p0;
            hs_p1_q    <= hs_p0;
            vs_p1_q    <= vs_p0;
            first_p1_q <= first_p0;
        end
    end

`ifdef VIDEO_SCANNER_BORDER_EN
    localparam logic [7:0]  FIELD_W8   = 8'(FIELD_W);
    localparam logic [7:0]  FIELD_H8   = 8'(FIELD_H);
    localparam logic [23:0] BORDER_RGB = 24'h404040;

    logic infield_p0, infield_p1_q;

    assign infield_p0 = (video_x < FIELD_W8) && (video_y < FIELD_H8);

    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            infield_p1_q <= 1'b0;
        end else begin
            infield_p1_q <= infield_p0;
        end
    end

    assign pix_sel = infield_p1_q ? pixel_in : BORDER_RGB;
`else
    assign pix_sel = pixel_in;
`endif

    // Stage 2: colour sampled from the renderer, blanking and sync polarity applied.
    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            rgb_q   <= '0;
            hsync_q <= sync_level(1'b0);
            vsync_q <= sync_level(1'b0);
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            rgb_q   <= de_p1_q ? pix_sel : '0;
            hsync_q <= sync_level(hs_p1_q);
            vsync_q <= sync_level(vs_p1_q);
            de_q    <= de_p1_q;
            fs_q    <= first_p1_q;
        end
    end

    assign rgb         = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_video_scanner.sv
// tb_video_scanner: raster-model checker for video_scanner with a shortened frame (42 lines of 800 pixels)
// so a full frame, a second frame start and a mid-frame reset fit in a short run.
`timescale 1ns/1ps
module tb_video_scanner;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 36,  VF = 2,  VS = 2,  VB = 2;
    localparam int CS = 4,   FW = 20, FH = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        video_clk = 1'b0;
    logic        reset     = 1'b1;
    logic [7:0]  video_x, video_y;
    logic [23:0] pixel_in  = 24'h0;
    logic [23:0] rgb;
    logic        hsync, vsync, de, frame_start;

    int checks   = 0;
    int failures = 0;
    int m        = 0;
    int cyc      = 0;
    bit rec_en   = 1'b1;
    logic [23:0] rend_cap = 24'h0;
    logic p_de = 1'b0, p_hs = 1'b1, p_vs = 1'b1;
    int de_rise[$], de_fall[$], hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_at[$];

    video_scanner #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CELL_SHIFT(CS), .FIELD_W(FW), .FIELD_H(FH), .SYNC_NEG(1'b1)
    ) dut (
        .video_clk  (video_clk),
        .reset      (reset),
        .video_x    (video_x),
        .video_y    (video_y),
        .pixel_in   (pixel_in),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .frame_start(frame_start)
    );

    always #5 video_clk = ~video_clk;

    // Renderer: registers {video_x, video_y, 5A} and returns it one clock later.
    always @(negedge video_clk) rend_cap = {video_x, video_y, 8'h5A};
    always @(posedge video_clk) begin
        #1;
        pixel_in = rend_cap;
    end

    always @(posedge video_clk) cyc++;
    always @(posedge video_clk or posedge reset) begin
        if (reset) m = 0;
        else       m = m + 1;
    end

    // Expected outputs after mm clock edges since reset release.
    function automatic void model(input int mm, output logic [7:0] ex, output logic [7:0] ey,
                                  output logic [23:0] ergb, output logic ehs, output logic evs,
                                  output logic ede, output logic efs);
        int h, v, p, ph, pv;
        bit border;
        h    = mm % HT;
        v    = (mm / HT) % VT;
        ex   = (h < HA) ? 8'(h >> CS) : 8'hFF;
        ey   = (v < VA) ? 8'(v >> CS) : 8'hFF;
        ergb = 24'h0;
        ehs  = 1'b1;
        evs  = 1'b1;
        ede  = 1'b0;
        efs  = 1'b0;
        if (mm >= 2) begin
            p   = mm - 2;
            ph  = p % HT;
            pv  = (p / HT) % VT;
            ede = (ph < HA) && (pv < VA);
            ehs = !((ph >= HA + HF) && (ph < HA + HF + HS));
            evs = !((pv >= VA + VF) && (pv < VA + VF + VS));
            efs = (ph == 0) && (pv == 0);
            border = 1'b0;
`ifdef VIDEO_SCANNER_BORDER_EN
            border = ((ph >> CS) >= FW) || ((pv >> CS) >= FH);
`endif
            if (ede) ergb = border ? 24'h404040 : {8'(ph >> CS), 8'(pv >> CS), 8'h5A};
        end
    endfunction

    always @(negedge video_clk) begin
        logic [7:0]  ex, ey;
        logic [23:0] ergb;
        logic        ehs, evs, ede, efs;
        model(m, ex, ey, ergb, ehs, evs, ede, efs);
        checks++;
        if ({video_x, video_y, rgb, hsync, vsync, de, frame_start} !==
            {ex, ey, ergb, ehs, evs, ede, efs}) begin
            failures++;
            $display("FAIL raster m=%0d got x=%h y=%h rgb=%h hs=%b vs=%b de=%b fs=%b want x=%h y=%h rgb=%h hs=%b vs=%b de=%b fs=%b",
                     m, video_x, video_y, rgb, hsync, vsync, de, frame_start,
                     ex, ey, ergb, ehs, evs, ede, efs);
        end
    end

    always @(negedge video_clk) begin
        if (rec_en && !reset) begin
            if (de && !p_de)     de_rise.push_back(cyc);
            if (!de && p_de)     de_fall.push_back(cyc);
            if (!hsync && p_hs)  hs_fall.push_back(cyc);
            if (hsync && !p_hs)  hs_rise.push_back(cyc);
            if (!vsync && p_vs)  vs_fall.push_back(cyc);
            if (vsync && !p_vs)  vs_rise.push_back(cyc);
            if (frame_start)     fs_at.push_back(cyc);
        end
        p_de = de;
        p_hs = hsync;
        p_vs = vsync;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic wait_m(input int target);
        int n = 0;
        while (m < target && n < 60000) begin
            @(negedge video_clk);
            n++;
        end
        if (m != target) begin
            checks++;
            failures++;
            $display("FAIL wait_m got=%0d want=%0d", m, target);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1000000;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_rgb"}, 32'(rgb), 32'h0);
        check({tag, "_de"}, 32'(de), 32'd0);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_vx"}, 32'(video_x), 32'd0);
        check({tag, "_vy"}, 32'(video_y), 32'd0);
    endtask

    initial begin
        int n_rise;
        reset = 1'b1;
        repeat (3) @(posedge video_clk);
        #2;
        check_reset_state("rst");
        reset = 1'b0;
        @(negedge video_clk);

        wait_m(1);
        check("edge1_de", 32'(de), 32'd0);
        wait_m(2);
        check("edge2_de", 32'(de), 32'd1);
        check("edge2_fs", 32'(frame_start), 32'd1);
        check("edge2_rgb", 32'(rgb), 32'h00005A);
        wait_m(3);
        check("edge3_fs", 32'(frame_start), 32'd0);
        wait_m(2 + 320);
`ifdef VIDEO_SCANNER_BORDER_EN
        check("rgb_h320_v0", 32'(rgb), 32'h404040);
`else
        check("rgb_h320_v0", 32'(rgb), 32'h14005A);
`endif
        wait_m(2 + 640);
        check("blank_rgb", 32'(rgb), 32'h0);
        check("blank_de", 32'(de), 32'd0);
        wait_m(2 + 20 * 800 + 37);
        check("rgb_h37_v20", 32'(rgb), 32'h02015A);
        wait_m(2 + 33 * 800 + 37);
`ifdef VIDEO_SCANNER_BORDER_EN
        check("rgb_h37_v33", 32'(rgb), 32'h404040);
`else
        check("rgb_h37_v33", 32'(rgb), 32'h02025A);
`endif
        wait_m(2 + 33600);
        check("frame2_fs", 32'(frame_start), 32'd1);
        wait_m(3 + 33600);
        rec_en = 1'b0;

        check("de_period", 32'(q_at(de_rise, 1) - q_at(de_rise, 0)), 32'd800);
        check("de_high_len", 32'(q_at(de_fall, 0) - q_at(de_rise, 0)), 32'd640);
        check("hs_fall_ofs", 32'(q_at(hs_fall, 0) - q_at(de_rise, 0)), 32'd656);
        check("hs_low_len", 32'(q_at(hs_rise, 0) - q_at(hs_fall, 0)), 32'd96);
        check("vs_low_len", 32'(q_at(vs_rise, 0) - q_at(vs_fall, 0)), 32'd1600);
        check("vs_fall_ofs", 32'(q_at(vs_fall, 0) - q_at(fs_at, 0)), 32'd30400);
        check("fs_period", 32'(q_at(fs_at, 1) - q_at(fs_at, 0)), 32'd33600);
        check("fs_count", 32'(fs_at.size()), 32'd2);
        n_rise = 0;
        foreach (de_rise[i]) if (de_rise[i] < q_at(fs_at, 1)) n_rise++;
        check("lines_per_frame", 32'(n_rise), 32'd36);

        wait_m(33600 + 10 * 800 + 300);
        check("pre_rst_vx", 32'(video_x), 32'd18);
        check("pre_rst_vy", 32'(video_y), 32'd0);
        check("pre_rst_de", 32'(de), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_state("midrst");
        repeat (2) @(posedge video_clk);
        #2 reset = 1'b0;
        @(negedge video_clk);
        wait_m(1);
        check("rel_edge1_de", 32'(de), 32'd0);
        check("rel_edge1_rgb", 32'(rgb), 32'h0);
        wait_m(2);
        check("rel_edge2_fs", 32'(frame_start), 32'd1);
        check("rel_edge2_rgb", 32'(rgb), 32'h00005A);
        wait_m(1700);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
